comb_lut_array: RTL and testbench

- Parametrised, registered successor to the fixed 4-input/3-output combinational function array.
- Holds N_OUT runtime-loadable truth tables over an N_IN-bit input and evaluates them with a valid/ready handshake.
- A built-in sweep engine walks every input value 0..2^N_IN-1 for self-characterisation.
- Sits between a config/control master and any consumer of per-input boolean flags.

---
 rtl/comb_lut_pkg.sv | 30 +++
 rtl/comb_lut_sweep_ctr.sv | 81 ++++++++
 rtl/comb_lut_array.sv | 132 +++++++++++++
 tb/tb_comb_lut_array.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comb_lut_pkg.sv
// Shared types and helpers for the comb_lut_array slice.
//   state_e  : sweep engine FSM state (StIdle, StSweep)
//   DefNIn   : default input vector width
//   DefNOut  : default number of output functions
//   tbl_w()  : truth-table width for a given input width (2^n_in)
//   fn_w()   : width of the table-select field (at least 1 bit)
//   idx_w()  : sweep index width; one spare bit so the terminal count never wraps
package comb_lut_pkg;

  localparam int unsigned DefNIn  = 4;
  localparam int unsigned DefNOut = 3;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } state_e;

  function automatic int unsigned tbl_w(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic int unsigned fn_w(input int unsigned n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/comb_lut_sweep_ctr.sv
// Sweep engine: walks index 0..2^N_IN-1, holding each index for DWELL cycles.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start_i   : start request (only honoured while idle)
//   busy_o    : high while sweeping
//   idx_o     : index currently presented
//   first_o   : current cycle is the first dwell cycle of idx_o
//   last_o    : current cycle is the final dwell cycle of the final index
module comb_lut_sweep_ctr
  import comb_lut_pkg::*;
#(
  parameter int unsigned N_IN  = DefNIn,
  parameter int unsigned DWELL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            busy_o,
  output logic [N_IN-1:0] idx_o,
  output logic            first_o,
  output logic            last_o
);

  localparam int unsigned IdxW = idx_w(N_IN);
  localparam int unsigned DwW  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [IdxW-1:0] LastIdx   = {1'b0, {N_IN{1'b1}}};
  localparam logic [DwW-1:0]  LastDwell = DwW'(DWELL - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [DwW-1:0]  dwell_q, dwell_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    last_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSweep;
          idx_d   = '0;
          dwell_d = '0;
        end
      end
      StSweep: begin
        if (dwell_q == LastDwell) begin
          dwell_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            last_o  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
    end
  end

  assign busy_o  = (state_q == StSweep);
  assign idx_o   = idx_q[N_IN-1:0];
  assign first_o = busy_o && (dwell_q == '0);

endmodule

// File: rtl/comb_lut_array.sv
// Array of N_OUT runtime-loadable truth tables over an N_IN-bit input, evaluated
// with a 1-cycle registered valid/ready path, plus a self-characterisation sweep.
// Optional build macro: COMB_LUT_ARRAY_PARITY_EN adds out_par = ^out_f.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   cfg_we/cfg_fn/cfg_data: table write (cfg_fn >= N_OUT ignored)
//   in_valid/in_a/in_ready: evaluation request handshake
//   sweep_start/busy/done : sweep control and status
//   out_valid/out_a/out_f : registered result (out_f[k] = table[k][out_a])
//   out_par               : (parity build only) XOR of out_f
module comb_lut_array
  import comb_lut_pkg::*;
#(
  parameter int unsigned N_IN  = DefNIn,
  parameter int unsigned N_OUT = DefNOut,
  parameter int unsigned DWELL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [fn_w(N_OUT)-1:0]   cfg_fn,
  input  logic [tbl_w(N_IN)-1:0]   cfg_data,
  input  logic                     in_valid,
  input  logic [N_IN-1:0]          in_a,
  output logic                     in_ready,
  input  logic                     sweep_start,
  output logic                     sweep_busy,
  output logic                     sweep_done,
  output logic                     out_valid,
  output logic [N_IN-1:0]          out_a,
  output logic [N_OUT-1:0]         out_f
`ifdef COMB_LUT_ARRAY_PARITY_EN
  ,
  output logic                     out_par
`endif
);

  localparam int unsigned TblW = tbl_w(N_IN);

  logic [TblW-1:0]  tbl_q [N_OUT];
  logic             fn_ok;
  logic             busy;
  logic [N_IN-1:0]  sweep_idx;
  logic             sweep_first;
  logic             sweep_last;
  logic             accept;
  logic             fire;
  logic [N_IN-1:0]  sel_a;
  logic [N_OUT-1:0] lut_f;

  logic             out_valid_q;
  logic [N_IN-1:0]  out_a_q;
  logic [N_OUT-1:0] out_f_q;
  logic             sweep_done_q;

  comb_lut_sweep_ctr #(
    .N_IN  (N_IN),
    .DWELL (DWELL)
  ) u_sweep_ctr (
    .clk     (clk),
    .rst     (rst),
    .start_i (sweep_start),
    .busy_o  (busy),
    .idx_o   (sweep_idx),
    .first_o (sweep_first),
    .last_o  (sweep_last)
  );

  assign fn_ok    = (32'(cfg_fn) < N_OUT);
  assign in_ready = ~busy;
  // A same-cycle sweep_start wins over an evaluation request.
  assign accept   = in_valid && in_ready && !sweep_start;
  assign fire     = accept || sweep_first;
  assign sel_a    = busy ? sweep_idx : in_a;

  // Reads the registered tables, so a same-cycle write is not yet visible.
  always_comb begin
    lut_f = '0;
    for (int k = 0; k < N_OUT; k++) begin
      lut_f[k] = tbl_q[k][sel_a];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        tbl_q[k] <= '0;
      end
    end else if (cfg_we && fn_ok) begin
      tbl_q[cfg_fn] <= cfg_data;
    end
  end

  // The done pulse marks the end of the last index's dwell, so a full sweep
  // spans exactly 2^N_IN*DWELL cycles from start to done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_f_q      <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      out_valid_q  <= fire;
      sweep_done_q <= sweep_last;
      if (fire) begin
        out_a_q <= sel_a;
        out_f_q <= lut_f;
      end
    end
  end

`ifdef COMB_LUT_ARRAY_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (fire) begin
      par_q <= ^lut_f;
    end
  end

  assign out_par = par_q;
`endif

  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_f      = out_f_q;
  assign sweep_done = sweep_done_q;
  assign sweep_busy = busy;

endmodule

// File: tb/tb_comb_lut_array.sv
// Bench for comb_lut_array: two instances (DWELL=1 and DWELL=4) share one set of
// inputs; their outputs are compared against a table-level reference model.
module tb_comb_lut_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_fn;
  logic [15:0] cfg_data;
  logic        in_valid;
  logic [3:0]  in_a;
  logic        sweep_start;

  logic        o1_ready, o1_busy, o1_done, o1_valid;
  logic [3:0]  o1_a;
  logic [2:0]  o1_f;
  logic        o4_ready, o4_busy, o4_done, o4_valid;
  logic [3:0]  o4_a;
  logic [2:0]  o4_f;
`ifdef COMB_LUT_ARRAY_PARITY_EN
  logic        o1_par, o4_par;
`endif

  always #5 clk = ~clk;

  comb_lut_array #(.N_IN(4), .N_OUT(3), .DWELL(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_fn      (cfg_fn),
    .cfg_data    (cfg_data),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_ready    (o1_ready),
    .sweep_start (sweep_start),
    .sweep_busy  (o1_busy),
    .sweep_done  (o1_done),
    .out_valid   (o1_valid),
    .out_a       (o1_a),
    .out_f       (o1_f)
`ifdef COMB_LUT_ARRAY_PARITY_EN
    ,
    .out_par     (o1_par)
`endif
  );

  comb_lut_array #(.N_IN(4), .N_OUT(3), .DWELL(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_fn      (cfg_fn),
    .cfg_data    (cfg_data),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_ready    (o4_ready),
    .sweep_start (sweep_start),
    .sweep_busy  (o4_busy),
    .sweep_done  (o4_done),
    .out_valid   (o4_valid),
    .out_a       (o4_a),
    .out_f       (o4_f)
`ifdef COMB_LUT_ARRAY_PARITY_EN
    ,
    .out_par     (o4_par)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: table contents and the last result each instance holds.
  logic [15:0] tbl [3];
  logic [3:0]  ha  [2];
  logic [2:0]  hf  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] lut(input logic [3:0] a);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = tbl[k][a];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic ev1, input logic ed1, input logic eb1,
                            input logic ev4, input logic ed4, input logic eb4);
    check_eq({tag, ".d1.valid"}, o1_valid, ev1);
    check_eq({tag, ".d1.a"},     o1_a,     ha[0]);
    check_eq({tag, ".d1.f"},     o1_f,     hf[0]);
    check_eq({tag, ".d1.done"},  o1_done,  ed1);
    check_eq({tag, ".d1.busy"},  o1_busy,  eb1);
    check_eq({tag, ".d1.ready"}, o1_ready, !eb1);
    check_eq({tag, ".d4.valid"}, o4_valid, ev4);
    check_eq({tag, ".d4.a"},     o4_a,     ha[1]);
    check_eq({tag, ".d4.f"},     o4_f,     hf[1]);
    check_eq({tag, ".d4.done"},  o4_done,  ed4);
    check_eq({tag, ".d4.busy"},  o4_busy,  eb4);
    check_eq({tag, ".d4.ready"}, o4_ready, !eb4);
`ifdef COMB_LUT_ARRAY_PARITY_EN
    check_eq({tag, ".d1.par"}, o1_par, ^hf[0]);
    check_eq({tag, ".d4.par"}, o4_par, ^hf[1]);
`endif
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) tbl[k] = '0;
    for (int u = 0; u < 2; u++) begin
      ha[u] = '0;
      hf[u] = '0;
    end
  endtask

  // One idle-mode cycle: optional evaluation and optional table write.
  task automatic eval_step(input string tag, input logic [3:0] a, input logic v, input logic we,
                           input logic [1:0] fn, input logic [15:0] data);
    in_valid = v;
    in_a     = a;
    cfg_we   = we;
    cfg_fn   = fn;
    cfg_data = data;
    cycle();
    if (v) begin
      for (int u = 0; u < 2; u++) begin
        ha[u] = a;
        hf[u] = lut(a);
      end
    end
    check_both(tag, v, 1'b0, 1'b0, v, 1'b0, 1'b0);
    if (we && fn < 2'd3) tbl[fn] = data;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  // Starts a sweep (with a competing request that must lose) and checks
  // stop_c cycles of both instances against the index/dwell timeline.
  task automatic run_sweep(input string tag, input int stop_c);
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_a        = 4'd7;
    cycle();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    check_both({tag, ".start"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= stop_c; c++) begin
      logic ev [2];
      logic ed [2];
      logic eb [2];
      sweep_start = (c == 5);
      cycle();
      sweep_start = 1'b0;
      for (int u = 0; u < 2; u++) begin
        int d;
        int n;
        d = (u == 0) ? 1 : 4;
        n = 16 * d;
        ev[u] = 1'b0;
        ed[u] = 1'b0;
        eb[u] = 1'b0;
        if (c <= n) begin
          if ((c - 1) % d == 0) begin
            ev[u] = 1'b1;
            ha[u] = 4'((c - 1) / d);
            hf[u] = lut(ha[u]);
          end
          ed[u] = (c == n);
          eb[u] = (c < n);
        end
      end
      check_both(tag, ev[0], ed[0], eb[0], ev[1], ed[1], eb[1]);
    end
  endtask

  initial begin
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_fn      = '0;
    cfg_data    = '0;
    in_valid    = 1'b0;
    in_a        = '0;
    sweep_start = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_both("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle();
    check_both("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // AND4, OR4, XOR4
    eval_step("load0", 4'd0, 1'b0, 1'b1, 2'd0, 16'h8000);
    eval_step("load1", 4'd0, 1'b0, 1'b1, 2'd1, 16'hFFFE);
    eval_step("load2", 4'd0, 1'b0, 1'b1, 2'd2, 16'h6996);
    eval_step("eval15", 4'd15, 1'b1, 1'b0, 2'd0, 16'h0);
    check_eq("eval15.const", o1_f, 3'b011);
    eval_step("eval1", 4'd1, 1'b1, 1'b0, 2'd0, 16'h0);
    check_eq("eval1.const", o1_f, 3'b110);
    eval_step("eval0", 4'd0, 1'b1, 1'b0, 2'd0, 16'h0);
    check_eq("eval0.const", o1_f, 3'b000);
    eval_step("idle_hold", 4'd9, 1'b0, 1'b0, 2'd0, 16'h0);
    // Back-to-back throughput
    for (int i = 0; i < 16; i++) eval_step("b2b", 4'(i), 1'b1, 1'b0, 2'd0, 16'h0);

    run_sweep("sweep", 66);

    // Write collides with evaluation of the same table
    eval_step("collide", 4'd1, 1'b1, 1'b1, 2'd2, 16'h0000);
    check_eq("collide.old", o1_f[2], 1'b1);
    eval_step("collide_next", 4'd1, 1'b1, 1'b0, 2'd0, 16'h0);
    check_eq("collide.new", o1_f[2], 1'b0);
    eval_step("fn3_write", 4'd0, 1'b0, 1'b1, 2'd3, 16'hFFFF);
    eval_step("fn3_eval", 4'd15, 1'b1, 1'b0, 2'd0, 16'h0);
    eval_step("fn3_eval0", 4'd0, 1'b1, 1'b0, 2'd0, 16'h0);
    eval_step("fn1_clear", 4'd0, 1'b0, 1'b1, 2'd1, 16'h0000);
    eval_step("fn1_eval", 4'd1, 1'b1, 1'b0, 2'd0, 16'h0);

    for (int i = 0; i < 300; i++) begin
      eval_step("rand", 4'($urandom_range(0, 15)), 1'($urandom % 2), ($urandom % 4) == 0,
                2'($urandom_range(0, 3)), 16'($urandom));
    end

    // Reset mid-sweep, around index 5 of the DWELL=4 instance
    eval_step("pre_rst_load", 4'd0, 1'b0, 1'b1, 2'd0, 16'hFFFF);
    run_sweep("sweep_cut", 21);
    #3 rst = 1'b1;
    #1;
    clear_model();
    check_both("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_both("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle();
    check_both("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sweep("sweep_zero", 66);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
